// File: rtl/pipeline_ctrl_reg_gen_if.sv
// Bus bundle for pipeline_ctrl_reg_gen: upstream control/handshake inputs and the
// registered slot outputs. The master drives the pipeline, the slave is the register.
interface pipeline_ctrl_reg_gen_if #(
    parameter int CTRL_W = 4,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic              valid_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              stall_i;
    logic              flush_i;
    logic              flush_all_i;
    logic              cnt_clr_i;
    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [OCC_W-1:0]  occupancy_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output valid_i, ctrl_i, stall_i, flush_i, flush_all_i, cnt_clr_i,
        input  valid_o, ctrl_o, occupancy_o, bubble_cnt_o
    );

    modport slave (
        input  valid_i, ctrl_i, stall_i, flush_i, flush_all_i, cnt_clr_i,
        output valid_o, ctrl_o, occupancy_o, bubble_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl_reg_gen.sv
// Control-bundle pipeline register: STAGES slots with stall, flush, global kill,
// write-enable squash of bubbles, occupancy and a saturating bubble counter.
module pipeline_ctrl_reg_gen #(
    parameter int                CTRL_W  = 4,
    parameter int                STAGES  = 1,
    parameter logic [CTRL_W-1:0] WE_MASK = 4'b0011,
    parameter int                CNT_W   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    pipeline_ctrl_reg_gen_if.slave  bus
);
    localparam int               OCC_W   = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Side-effect bits of an invalid bundle are cleared so a bubble can never write.
    function automatic logic [CTRL_W-1:0] squash_we(input logic vld, input logic [CTRL_W-1:0] ctrl);
        logic [CTRL_W-1:0] res;
        if (vld) begin
            res = ctrl;
        end else begin
            res = ctrl & ~WE_MASK;
        end
        return res;
    endfunction

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = {OCC_W{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    logic [STAGES-1:0]             slot_v_r;
    logic [STAGES-1:0]             slot_v_s;
    logic [STAGES-1:0][CTRL_W-1:0] slot_c_r;
    logic [STAGES-1:0][CTRL_W-1:0] slot_c_s;
    logic [OCC_W-1:0]              occ_r;
    logic [CNT_W-1:0]              bubble_cnt_r;
    logic [CNT_W-1:0]              bubble_cnt_s;

    // Slot next-state: kill, stall(+flush), flush, or normal advance.
    always_comb begin
        slot_v_s = slot_v_r;
        slot_c_s = slot_c_r;
        if (bus.flush_all_i) begin
            slot_v_s = {STAGES{1'b0}};
            slot_c_s = '0;
        end else if (bus.stall_i) begin
            if (bus.flush_i) begin
                slot_v_s[0] = 1'b0;
                slot_c_s[0] = {CTRL_W{1'b0}};
            end else begin
                slot_v_s = slot_v_r;
            end
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                slot_v_s[k] = slot_v_r[k-1];
                slot_c_s[k] = slot_c_r[k-1];
            end
            if (bus.flush_i) begin
                slot_v_s[0] = 1'b0;
                slot_c_s[0] = {CTRL_W{1'b0}};
            end else begin
                slot_v_s[0] = bus.valid_i;
                slot_c_s[0] = squash_we(bus.valid_i, bus.ctrl_i);
            end
        end
    end

    // Bubble counter next value; a stalled cycle is not counted as a bubble.
    always_comb begin
        bubble_cnt_s = bubble_cnt_r;
        if (bus.cnt_clr_i) begin
            bubble_cnt_s = {CNT_W{1'b0}};
        end else if (!slot_v_r[STAGES-1] && !bus.stall_i && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_s = bubble_cnt_r + CNT_W'(1);
        end else begin
            bubble_cnt_s = bubble_cnt_r;
        end
    end

    // State registers: slots, occupancy and bubble counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_v_r     <= {STAGES{1'b0}};
            slot_c_r     <= '0;
            occ_r        <= {OCC_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            slot_v_r     <= slot_v_s;
            slot_c_r     <= slot_c_s;
            occ_r        <= popcount(slot_v_s);
            bubble_cnt_r <= bubble_cnt_s;
        end
    end

    assign bus.valid_o      = slot_v_r[STAGES-1];
    assign bus.ctrl_o       = slot_c_r[STAGES-1];
    assign bus.occupancy_o  = occ_r;
    assign bus.bubble_cnt_o = bubble_cnt_r;
endmodule

// File: tb/tb_pipeline_ctrl_reg_gen.sv
// Directed bench: a 1-stage (4-bit counter) and a 3-stage instance share stimulus and
// are compared every cycle against a slot-list model, plus hand-computed literal checks.
module tb_pipeline_ctrl_reg_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [3:0] ctrl_i = 4'h0;
    logic       stall_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       flush_all_i = 1'b0;
    logic       cnt_clr_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_reg_gen_if #(.CTRL_W(4), .STAGES(1), .CNT_W(4))  ifa ();
    pipeline_ctrl_reg_gen_if #(.CTRL_W(4), .STAGES(3), .CNT_W(16)) ifb ();

    assign ifa.valid_i = valid_i;     assign ifb.valid_i = valid_i;
    assign ifa.ctrl_i = ctrl_i;       assign ifb.ctrl_i = ctrl_i;
    assign ifa.stall_i = stall_i;     assign ifb.stall_i = stall_i;
    assign ifa.flush_i = flush_i;     assign ifb.flush_i = flush_i;
    assign ifa.flush_all_i = flush_all_i; assign ifb.flush_all_i = flush_all_i;
    assign ifa.cnt_clr_i = cnt_clr_i; assign ifb.cnt_clr_i = cnt_clr_i;

    pipeline_ctrl_reg_gen #(.CTRL_W(4), .STAGES(1), .WE_MASK(4'b0011), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifa.slave));
    pipeline_ctrl_reg_gen #(.CTRL_W(4), .STAGES(3), .WE_MASK(4'b0011), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(ifb.slave));

    // Model: per instance, a list of slots (index 0 = input side) and a bubble count.
    bit         mv [2][3];
    logic [3:0] mc [2][3];
    int         mcnt [2];
    int         depth [2] = '{1, 3};
    int         cmax  [2] = '{15, 65535};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            for (int k = 0; k < 3; k++) begin
                mv[d][k] = 1'b0;
                mc[d][k] = 4'h0;
            end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int last;
            last = depth[d] - 1;
            if (cnt_clr_i) mcnt[d] = 0;
            else if (!mv[d][last] && !stall_i && mcnt[d] < cmax[d]) mcnt[d]++;
            if (flush_all_i) begin
                for (int k = 0; k < 3; k++) begin mv[d][k] = 1'b0; mc[d][k] = 4'h0; end
            end else if (stall_i) begin
                if (flush_i) begin mv[d][0] = 1'b0; mc[d][0] = 4'h0; end
            end else begin
                for (int k = 2; k >= 1; k--) begin mv[d][k] = mv[d][k-1]; mc[d][k] = mc[d][k-1]; end
                if (flush_i) begin
                    mv[d][0] = 1'b0; mc[d][0] = 4'h0;
                end else begin
                    mv[d][0] = valid_i;
                    mc[d][0] = valid_i ? ctrl_i : (ctrl_i & 4'b1100);
                end
            end
        end
    endtask

    // One clock edge: model follows the edge, return at the following falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic int occ_of(input int d);
        int n;
        n = 0;
        for (int k = 0; k < depth[d]; k++) n += int'(mv[d][k]);
        return n;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("a_valid", int'(ifa.valid_o), int'(mv[0][0]));
        check("a_ctrl", int'(ifa.ctrl_o), int'(mc[0][0]));
        check("a_occ", int'(ifa.occupancy_o), occ_of(0));
        check("a_bcnt", int'(ifa.bubble_cnt_o), mcnt[0]);
        check("b_valid", int'(ifb.valid_o), int'(mv[1][2]));
        check("b_ctrl", int'(ifb.ctrl_o), int'(mc[1][2]));
        check("b_occ", int'(ifb.occupancy_o), occ_of(1));
        check("b_bcnt", int'(ifb.bubble_cnt_o), mcnt[1]);
    end

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-stage flow.
        valid_i = 1'b1; ctrl_i = 4'hB;
        step();
        check("t1_valid", int'(ifa.valid_o), 1);
        check("t1_ctrl", int'(ifa.ctrl_o), 11);
        check("t1_occ", int'(ifa.occupancy_o), 1);

        // Asynchronous reset mid-cycle clears state before any edge.
        ctrl_i = 4'h5;
        step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", int'(ifa.valid_o), 0);
        check("rst_ctrl", int'(ifa.ctrl_o), 0);
        check("rst_occ", int'(ifb.occupancy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-stage latency.
        for (int i = 1; i <= 6; i++) begin
            ctrl_i = 4'(i);
            step();
            if (i == 3) begin
                check("t2_first", int'(ifb.ctrl_o), 1);
                check("t2_occ", int'(ifb.occupancy_o), 3);
            end
            if (i == 4) check("t2_second", int'(ifb.ctrl_o), 2);
        end

        // Stall holds everything; stall+flush bubbles only slot 0.
        stall_i = 1'b1; ctrl_i = 4'h9;
        step();
        step();
        check("t3_hold", int'(ifb.ctrl_o), 4);
        flush_i = 1'b1;
        step();
        check("t3_occ", int'(ifb.occupancy_o), 2);
        check("t3_ctrl", int'(ifb.ctrl_o), 4);
        stall_i = 1'b0; flush_i = 1'b0;

        // Flush alone inserts a bubble while the pipe advances.
        ctrl_i = 4'h7; step();
        flush_i = 1'b1; ctrl_i = 4'h8; step();
        flush_i = 1'b0; ctrl_i = 4'hA; step();
        ctrl_i = 4'hD; step();
        ctrl_i = 4'hE; step();

        // Global kill beats stall and flush, nothing captured.
        flush_all_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1; ctrl_i = 4'h6;
        step();
        check("t5_valid", int'(ifb.valid_o), 0);
        check("t5_ctrl", int'(ifb.ctrl_o), 0);
        check("t5_occ", int'(ifb.occupancy_o), 0);
        check("t5_a_ctrl", int'(ifa.ctrl_o), 0);
        flush_all_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

        // Squash of write-enable bits on an invalid capture.
        valid_i = 1'b0; ctrl_i = 4'hF;
        step();
        check("t4_ctrl", int'(ifa.ctrl_o), 12);
        check("t4_valid", int'(ifa.valid_o), 0);

        // Counter saturation, then clear and resume.
        cnt_clr_i = 1'b1; step();
        check("t6_clr0", int'(ifa.bubble_cnt_o), 0);
        cnt_clr_i = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("t6_sat", int'(ifa.bubble_cnt_o), 15);
        cnt_clr_i = 1'b1; step();
        check("t6_clr", int'(ifa.bubble_cnt_o), 0);
        cnt_clr_i = 1'b0; step();
        check("t6_resume", int'(ifa.bubble_cnt_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl_reg_gen.md
Name: pipeline_ctrl_reg_gen

Overview:
Parametrised control-bundle pipeline register for the RV32 core's stage boundaries (E/M, M/W and deeper FP/mul-div paths). It carries a CTRL_W-bit control bundle plus a valid bit through STAGES back-to-back register slots.
- Per-boundary stall: hold.
- Flush: bubble insertion into the first slot.
- Global kill: flush_all.
- Bubble write-enable squash via mask.
- Occupancy count and saturating bubble counter for performance monitoring.

Parameters:
CTRL_W, 4, control bundle width; bit 0 = reg_write, bit 1 = mem_write, bits 3:2 = result_src in the default E/M use.
STAGES, 1, number of register slots, must be ≥1; the slot index of stage 0 is the input side.
WE_MASK, 4'b0011, bits of the bundle that have side effects; forced to 0 whenever the slot is invalid.
CNT_W, 16, bubble counter width.

Ports:
clk_i  in  1  clock, all state updates on rising edge.
rst_n_i  in  1  reset; asynchronous assertion, active-low.
valid_i  in  1  upstream instruction valid.
ctrl_i  in  CTRL_W  upstream control bundle.
stall_i  in  1  hold all slots.
flush_i  in  1  replace slot 0 capture with a bubble.
flush_all_i  in  1  invalidate every slot (trap/redirect).
cnt_clr_i  in  1  synchronous clear of bubble counter.
valid_o  out  1  valid of last slot.
ctrl_o  out  CTRL_W  bundle of last slot.
occupancy_o  out  $clog2(STAGES+1)  number of valid slots.
bubble_cnt_o  out  CNT_W  saturating count of cycles with valid_o=0 and stall_i=0.

Behaviour:
- Reset (rst_n_i low, async): all slot valid=0, all ctrl=0, occupancy_o=0, bubble_cnt_o=0. Outputs are held at 0 until the first rising edge after deassertion; reset asserted mid-operation discards all in-flight slots immediately.
- Bubble definition: valid=0, ctrl=0.
- Capture squash: when valid_i=0 is captured, ctrl_i bits where WE_MASK=1 are stored as 0; non-masked bits are stored as given.
- Per rising edge, priority highest first:
  1. flush_all_i=1: every slot becomes a bubble, regardless of stall_i and flush_i.
  2. stall_i=1 and flush_i=1: slot 0 becomes a bubble; slots 1..STAGES-1 hold.
  3. stall_i=1 only: all slots hold; no new capture.
  4. flush_i=1 only: slot 0 ← bubble; slot k ← slot k-1 for k≥1.
  5. Otherwise: slot 0 ← {valid_i, squashed ctrl_i}; slot k ← slot k-1.
- Latency: valid_i/ctrl_i appear on valid_o/ctrl_o exactly STAGES unstalled edges after capture. Outputs are registered; there is no combinational input→output path.
- STAGES=1 is a single E/M-style register with stall/flush added.
- occupancy_o: registered popcount of slot valid bits, updated together with the slots; range 0..STAGES.
- Bubble counter:
  - Increments on an edge where valid_o=0 and stall_i=0 (a stall is not a bubble).
  - Saturates at 2^CNT_W−1; no wrap.
  - cnt_clr_i has priority over increment and loads 0.
  - flush_all_i does not clear it.
- The invariant ctrl_o & WE_MASK == 0 whenever valid_o=0 holds at all times.

Test Plan:
1. Reset/flow, STAGES=1: assert rst_n_i=0 mid-cycle → outputs 0 before the next edge. Release, then drive valid_i=1, ctrl_i=4'hB → valid_o=1, ctrl_o=4'hB after 1 edge; occupancy_o=1.
2. Depth/latency, STAGES=3: stream ctrl 1,2,3,4 with valid_i=1 → ctrl_o shows 1 at edge 3, then 2, 3, 4 on consecutive edges; occupancy_o reaches 3.
3. Stall+flush interplay, STAGES=3, slots holding {A,B,C}:
   - stall_i=1 for 2 cycles → ctrl_o stays C; bubble_cnt_o unchanged.
   - stall_i=1 with flush_i=1 → slot 0 becomes a bubble, slots 1–2 held; occupancy_o drops from 3 to 2.
4. Squash, STAGES=1: valid_i=0, ctrl_i=4'hF → ctrl_o=4'hC (WE bits 1:0 cleared), valid_o=0.
5. flush_all_i together with stall_i=1 and flush_i=1, slots full → next edge all slots invalid, occupancy_o=0, ctrl_o=0. Incoming ctrl_i is not captured.
6. Counter, CNT_W=4: idle with valid_i=0 for 20 unstalled cycles → bubble_cnt_o saturates at 15. cnt_clr_i=1 asserted while a bubble is present → 0 on the next edge, increments resume the edge after.
